// File: rtl/pixel_capture.sv
// pixel_capture
//   Camera-side capture stage between the OV7670 parallel pixel bus and the
//   pixel frame BRAM. Runs entirely in the camera PCLK domain. After camera
//   init completes, frames each image on VSYNC/HREF, pairs RGB444 byte pairs
//   into 12-bit pixels and writes them at sequential frame-relative addresses,
//   saturating at the frame buffer capacity.
//
// Ports
//   i_clk        camera PCLK, rising edge
//   i_rst        asynchronous active-high reset
//   i_cam_done   camera register init complete (level)
//   i_vsync      camera VSYNC, high = vertical blanking
//   i_href       camera HREF, high = valid byte on i_pix_byte
//   i_pix_byte   camera data byte
//   o_pix_wr     BRAM write enable, one-cycle pulse per pixel
//   o_pix_addr   BRAM write address
//   o_pix_data   RGB444 pixel {R,G,B}
//   o_frame_done one-cycle pulse at end of a captured frame
//   o_ovf        sticky per frame: capacity exceeded or odd byte count on a line
module pixel_capture #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cam_done,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_pix_byte,
    output logic              o_pix_wr,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [11:0]       o_pix_data,
    output logic              o_frame_done,
    output logic              o_ovf
);

    localparam logic [ADDR_W-1:0] CAPACITY = ADDR_W'(H_PIXELS * V_LINES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE
    } state_t;

    state_t            state_q;
    logic              vsync_q;
    logic              href_q;
    logic              phase_q;
    logic [3:0]        red_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pix_wr_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [11:0]       pix_data_q;
    logic              frame_done_q;
    logic              ovf_q;

    logic vsync_fall;
    logic vsync_rise;
    logic href_fall;

    assign vsync_fall = vsync_q & ~i_vsync;
    assign vsync_rise = ~vsync_q & i_vsync;
    assign href_fall  = href_q & ~i_href;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            red_q        <= '0;
            addr_q       <= '0;
            pix_wr_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            href_q       <= i_href;
            pix_wr_q     <= 1'b0;
            frame_done_q <= 1'b0;

            // Losing camera init overrides everything; a write registered on
            // the previous edge still drives its one-cycle pulse.
            if (!i_cam_done) begin
                state_q <= IDLE;
                phase_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= WAIT_FRAME;
                    end
                    WAIT_FRAME: begin
                        if (vsync_fall) begin
                            state_q <= CAPTURE;
                            addr_q  <= '0;
                            phase_q <= 1'b0;
                            ovf_q   <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (i_href) begin
                            if (!phase_q) begin
                                red_q   <= i_pix_byte[3:0];
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (addr_q < CAPACITY) begin
                                    pix_wr_q   <= 1'b1;
                                    pix_addr_q <= addr_q;
                                    pix_data_q <= {red_q, i_pix_byte};
                                    addr_q     <= addr_q + ADDR_W'(1);
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end
                        end else if (href_fall) begin
                            // A dangling first byte at line end is discarded.
                            phase_q <= 1'b0;
                            if (phase_q) begin
                                ovf_q <= 1'b1;
                            end
                        end

                        // Evaluated independently so a second byte coinciding
                        // with the vsync rise is still written.
                        if (vsync_rise) begin
                            frame_done_q <= 1'b1;
                            state_q      <= WAIT_FRAME;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_pix_wr     = pix_wr_q;
    assign o_pix_addr   = pix_addr_q;
    assign o_pix_data   = pix_data_q;
    assign o_frame_done = frame_done_q;
    assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture using a reduced 4x3 frame (capacity 12).
module tb_pixel_capture;

    localparam int unsigned HP  = 4;
    localparam int unsigned VL  = 3;
    localparam int unsigned AW  = 4;
    localparam int unsigned CAP = HP * VL;

    logic          clk = 1'b0;
    logic          rst;
    logic          cam_done;
    logic          vsync;
    logic          href;
    logic [7:0]    pix_byte;
    logic          pix_wr;
    logic [AW-1:0] pix_addr;
    logic [11:0]   pix_data;
    logic          frame_done;
    logic          ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [AW+11:0] got_q[$];
    logic [AW+11:0] exp_q[$];
    int unsigned    fd_cnt = 0;
    int unsigned    coincide_cnt = 0;
    int unsigned    exp_addr = 0;

    pixel_capture #(
        .H_PIXELS(HP),
        .V_LINES (VL),
        .ADDR_W  (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cam_done  (cam_done),
        .i_vsync     (vsync),
        .i_href      (href),
        .i_pix_byte  (pix_byte),
        .o_pix_wr    (pix_wr),
        .o_pix_addr  (pix_addr),
        .o_pix_data  (pix_data),
        .o_frame_done(frame_done),
        .o_ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_wr) got_q.push_back({pix_addr, pix_data});
        if (frame_done) fd_cnt++;
        if (pix_wr && frame_done) coincide_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int unsigned addr, input logic [11:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    task automatic send_byte(input logic [7:0] b);
        href     = 1'b1;
        pix_byte = b;
        tick();
    endtask

    // Sends one pixel with a random ignored upper nibble and updates the
    // expected write list (drops once the frame is full).
    task automatic send_pixel(input logic [11:0] px);
        send_byte({4'($urandom_range(15)), px[11:8]});
        send_byte(px[7:0]);
        if (exp_addr < CAP) begin
            expect_wr(exp_addr, px);
            exp_addr++;
        end
    endtask

    task automatic line_end();
        href = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_start();
        href  = 1'b0;
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        exp_addr = 0;
    endtask

    task automatic frame_end();
        href  = 1'b0;
        vsync = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic send_frame(input int unsigned lines);
        for (int unsigned l = 0; l < lines; l++) begin
            for (int unsigned p = 0; p < HP; p++) send_pixel(12'($urandom_range(4095)));
            line_end();
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i][AW+11:12]), 32'(exp_q[i][AW+11:12]));
            check($sformatf("%s_data%0d", tag, i), 32'(got_q[i][11:0]), 32'(exp_q[i][11:0]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        cam_done = 1'b0;
        vsync    = 1'b0;
        href     = 1'b0;
        pix_byte = 8'h00;
        #12;
        check("rst_wr",   32'(pix_wr),     0);
        check("rst_addr", 32'(pix_addr),   0);
        check("rst_data", 32'(pix_data),   0);
        check("rst_fd",   32'(frame_done), 0);
        check("rst_ovf",  32'(ovf),        0);
        tick();
        rst = 1'b0;
        tick();

        // Camera not ready: full traffic must produce no writes.
        frame_start();
        send_frame(VL);
        frame_end();
        check("nocam_writes", got_q.size(), 0);
        check("nocam_fd", fd_cnt, 0);
        got_q.delete();
        exp_q.delete();

        // First pixel after init.
        cam_done = 1'b1;
        tick();
        tick();
        fd_cnt = 0;
        frame_start();
        send_byte(8'hF1);
        send_byte(8'h23);
        line_end();
        expect_wr(0, 12'h123);
        frame_end();
        compare_writes("first");
        check("first_fd", fd_cnt, 1);

        // One full random frame.
        fd_cnt = 0;
        frame_start();
        send_frame(VL);
        frame_end();
        compare_writes("full");
        check("full_fd", fd_cnt, 1);
        check("full_ovf", 32'(ovf), 0);

        // One line too many: writes saturate, overflow flagged.
        fd_cnt = 0;
        frame_start();
        send_frame(VL + 1);
        check("sat_ovf", 32'(ovf), 1);
        frame_end();
        compare_writes("sat");

        // Next frame clears overflow; odd-length line.
        frame_start();
        check("odd_ovf_clr", 32'(ovf), 0);
        send_byte(8'hFA);
        send_byte(8'hBC);
        send_byte(8'hFD);
        line_end();
        expect_wr(0, 12'hABC);
        check("odd_ovf", 32'(ovf), 1);
        send_byte(8'h74);
        send_byte(8'h56);
        line_end();
        expect_wr(1, 12'h456);
        frame_end();
        compare_writes("odd");
        check("odd_fd", fd_cnt, 2);

        // Second byte coincides with vsync rise.
        fd_cnt       = 0;
        coincide_cnt = 0;
        frame_start();
        send_byte(8'h07);
        pix_byte = 8'h89;
        vsync    = 1'b1;
        tick();
        href = 1'b0;
        tick();
        tick();
        expect_wr(0, 12'h789);
        compare_writes("coin");
        check("coin_fd", fd_cnt, 1);
        check("coin_same", coincide_cnt, 1);

        // Camera init lost mid-frame: no frame_done, next frame restarts.
        fd_cnt = 0;
        frame_start();
        send_pixel(12'h111);
        send_byte(8'h0A);
        cam_done = 1'b0;
        href     = 1'b0;
        tick();
        cam_done = 1'b1;
        tick();
        vsync = 1'b1;
        tick();
        tick();
        check("drop_fd", fd_cnt, 0);
        compare_writes("drop");
        frame_start();
        send_pixel(12'h222);
        line_end();
        frame_end();
        compare_writes("drop_next");

        // Two consecutive frames.
        fd_cnt = 0;
        for (int unsigned f = 0; f < 2; f++) begin
            frame_start();
            send_frame(2);
            frame_end();
            compare_writes($sformatf("two%0d", f));
        end
        check("two_fd", fd_cnt, 2);

        // Reset asserted while a write pulse is on the outputs.
        frame_start();
        for (int unsigned p = 0; p < 5; p++) send_pixel(12'($urandom_range(4095)));
        rst = 1'b1;
        #1;
        check("mid_rst_wr",   32'(pix_wr),   0);
        check("mid_rst_addr", 32'(pix_addr), 0);
        check("mid_rst_data", 32'(pix_data), 0);
        check("mid_rst_ovf",  32'(ovf),      0);
        href = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();
        rst = 1'b0;
        tick();
        tick();
        frame_start();
        send_pixel(12'hABC);
        line_end();
        frame_end();
        compare_writes("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
